// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM controller family: FSM states, instruction fields, datapath selects.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  // Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Instr[24:21], supported data-processing commands
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Instr[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_RDATA  = 2'd1;
  localparam logic [1:0] RES_ALURES = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  function automatic logic cmd_legal(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_CMP);
  endfunction

  function automatic logic [1:0] alu_ctl(input logic [3:0] cmd);
    logic [1:0] r;
    case (cmd)
      CMD_SUB, CMD_CMP: r = ALU_SUB;
      CMD_AND:          r = ALU_AND;
      CMD_ORR:          r = ALU_ORR;
      default:          r = ALU_ADD;
    endcase
    return r;
  endfunction

  // Only arithmetic commands produce meaningful carry and overflow.
  function automatic logic cmd_sets_cv(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/condcheck.sv
// ARM condition-code evaluation against stored NZCV; cond 1111 never executes.
// Latency: combinational.
// Backpressure: not applicable.
// Ports: cond (Instr[31:28]), flags (NZCV), condex (1 = instruction executes).
import arm_ctrl_pkg::*;

module condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM controller: decodes Instr per state, holds NZCV, aborts stalled memory accesses.
// Latency: DP 4, LDR 5, STR 4, B 3 cycles with zero memory wait states.
// Backpressure: mem_req held until mem_ready; TIMEOUT_CYCLES unready cycles -> bus_err, back to FETCH.
// Ports: clk/reset (async, active-low); Instr, ALUFlags, addr_lo, mem_ready in;
//        memory (mem_req, AdrSrc, MemWrite, be), register/PC writes, datapath selects,
//        stored flags, illegal and bus_err pulses out.
import arm_ctrl_pkg::*;

module arm_mc_controller #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  addr_lo,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic [3:0]  be,
  output logic        RegWrite,
  output logic        LinkWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic [3:0]  flags,
  output logic        illegal,
  output logic        bus_err
);

  localparam int CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST_W = TO_LAST[CW-1:0];

  state_t        state;
  logic [CW-1:0] wait_cnt;

  // Instruction fields
  logic [1:0] op;
  logic [3:0] cmd;
  logic       imm_op, sbit, is_cmp, rd15, byte_acc, link;
  assign op       = Instr[27:26];
  assign cmd      = Instr[24:21];
  assign imm_op   = Instr[25];
  assign sbit     = Instr[20];
  assign is_cmp   = (cmd == CMD_CMP);
  assign rd15     = (Instr[15:12] == 4'hF);
  assign byte_acc = Instr[22];
  assign link     = Instr[24];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{Instr[23], Instr[19:16], Instr[11:0]};

  logic condex;
  condcheck u_condcheck (
    .cond   (Instr[31:28]),
    .flags  (flags),
    .condex (condex)
  );

  logic illegal_instr;
  assign illegal_instr = (Instr[31:28] == COND_NV) || (op == 2'b11) ||
                         ((op == OP_DP) && !cmd_legal(cmd));

  // A failed condition suppresses the data access entirely, so such a
  // state has nothing to wait for and advances without a handshake.
  logic mem_active;
  assign mem_active = (state == S_FETCH) ||
                      (((state == S_MEMREAD) || (state == S_MEMWRITE)) && condex);

  logic timeout;
  assign timeout = (TIMEOUT_CYCLES != 0) && mem_active && !mem_ready &&
                   (wait_cnt == TO_LAST_W);

  logic [3:0] be_acc;
  assign be_acc = byte_acc ? (4'b0001 << addr_lo) : 4'b1111;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      flags    <= 4'b0000;
      wait_cnt <= '0;
    end else begin
      // Counter restarts on every exit, including a timeout back into FETCH.
      if (mem_active && !mem_ready && !timeout)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;

      if ((state == S_ALUWB) && condex && (sbit || is_cmp)) begin
        flags[3:2] <= ALUFlags[3:2];
        if (cmd_sets_cv(cmd))
          flags[1:0] <= ALUFlags[1:0];
      end

      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (illegal_instr)       state <= S_FETCH;
          else if (op == OP_DP)    state <= imm_op ? S_EXECI : S_EXECR;
          else if (op == OP_MEM)   state <= S_MEMADR;
          else                     state <= S_BRANCH;
        end
        S_MEMADR:   state <= sbit ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: begin
          if (mem_ready || !condex) state <= S_MEMWB;
          else if (timeout)         state <= S_FETCH;
        end
        S_MEMWRITE: if (mem_ready || !condex || timeout) state <= S_FETCH;
        S_EXECR,
        S_EXECI:    state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    be         = 4'b0000;
    RegWrite   = 1'b0;
    LinkWrite  = 1'b0;
    RegSrc     = 2'b00;
    ImmSrc     = IMM_DP;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ALUControl = ALU_ADD;
    ResultSrc  = RES_ALUOUT;
    illegal    = 1'b0;
    bus_err    = timeout;

    // Instr is stale during FETCH, so register selects only follow it afterwards.
    if (state != S_FETCH)
      RegSrc = {(op == OP_MEM) && !sbit, op == OP_BR};

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        illegal = illegal_instr;
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_MEM;
      end
      S_MEMREAD: begin
        mem_req = condex;
        AdrSrc  = 1'b1;
        be      = be_acc;
      end
      S_MEMWRITE: begin
        mem_req  = condex;
        AdrSrc   = 1'b1;
        MemWrite = condex;
        be       = be_acc;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = condex && !rd15;
        PCWrite   = condex && rd15;
      end
      S_EXECR: begin
        ALUSrcB    = SRCB_REG;
        ALUControl = alu_ctl(cmd);
      end
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_DP;
        ALUControl = alu_ctl(cmd);
      end
      S_ALUWB: begin
        // Operands stay selected so ALUFlags still reflects this instruction.
        ALUSrcB    = imm_op ? SRCB_IMM : SRCB_REG;
        ALUControl = alu_ctl(cmd);
        ResultSrc  = RES_ALUOUT;
        RegWrite   = condex && !is_cmp && !rd15;
        PCWrite    = condex && !is_cmp && rd15;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_BR;
        ResultSrc = RES_ALURES;
        PCWrite   = condex;
        LinkWrite = condex && link;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed bench for arm_mc_controller: per-cycle expected control vectors go through a scoreboard queue.
// Latency: checks outputs #1 after each falling edge, inputs are applied on that same edge.
// Backpressure: mem_ready patterns exercise wait states, timeout and ready-wins-over-timeout.
module tb_arm_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  addr_lo;
  logic        mem_ready;
  logic        mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, LinkWrite;
  logic [3:0]  be, flags;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic        ALUSrcA, illegal, bus_err;

  arm_mc_controller #(.TIMEOUT_CYCLES(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .addr_lo    (addr_lo),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .be         (be),
    .RegWrite   (RegWrite),
    .LinkWrite  (LinkWrite),
    .RegSrc     (RegSrc),
    .ImmSrc     (ImmSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ResultSrc  (ResultSrc),
    .flags      (flags),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // Control vector: {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, LinkWrite, illegal, bus_err, be}
  localparam logic [12:0] NONE = 13'h0000;
  localparam logic [12:0] MREQ = 13'h1000;
  localparam logic [12:0] ADR  = 13'h0800;
  localparam logic [12:0] IRW  = 13'h0400;
  localparam logic [12:0] PCW  = 13'h0200;
  localparam logic [12:0] MW   = 13'h0100;
  localparam logic [12:0] RW   = 13'h0080;
  localparam logic [12:0] LW   = 13'h0040;
  localparam logic [12:0] ILL  = 13'h0020;
  localparam logic [12:0] BERR = 13'h0010;
  localparam logic [12:0] FOK  = 13'h1600;  // FETCH completing: MREQ|IRW|PCW

  localparam logic [31:0] I_BEQ  = 32'h0A000004;
  localparam logic [31:0] I_BLEQ = 32'h0B000004;
  localparam logic [31:0] I_ADDS = 32'hE0921003;
  localparam logic [31:0] I_CMP  = 32'hE1520003;
  localparam logic [31:0] I_ORRS = 32'hE1921003;
  localparam logic [31:0] I_ADPC = 32'hE082F003;
  localparam logic [31:0] I_STRB = 32'hE5C01000;
  localparam logic [31:0] I_STR  = 32'hE5801000;
  localparam logic [31:0] I_LDR  = 32'hE5901000;
  localparam logic [31:0] I_OP11 = 32'hEC000000;
  localparam logic [31:0] I_EOR  = 32'hE0221003;
  localparam logic [31:0] I_NV   = 32'hF0821003;

  logic [12:0] ctl_obs;
  logic [8:0]  sel_obs;
  assign ctl_obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, LinkWrite,
                    illegal, bus_err, be};
  assign sel_obs = {ALUSrcA, ALUSrcB, ALUControl, ResultSrc, ImmSrc};

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs on the falling edge, queue the expected
  // control vector, then compare once the decode has settled.
  task automatic step(input logic [31:0] ins, input logic rdy, input logic [3:0] af,
                      input logic [12:0] e, input string tag);
    @(negedge clk);
    Instr     = ins;
    mem_ready = rdy;
    ALUFlags  = af;
    exp_q.push_back(e);
    #1;
    check_eq(tag, 32'(ctl_obs), 32'(exp_q.pop_front()));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    Instr     = 32'h0;
    ALUFlags  = 4'h0;
    addr_lo   = 2'd2;
    mem_ready = 1'b0;
    #12;
    check_eq("rst_ctl", 32'(ctl_obs), 32'(MREQ));
    check_eq("rst_flags", 32'(flags), 32'(4'b0000));
    check_eq("rst_sel", 32'(sel_obs), 32'(9'b110001000));
    @(negedge clk);
    reset = 1'b1;

    // BEQ with Z clear: not taken
    step(I_BEQ, 1'b1, 4'h0, FOK,  "beq_fetch");
    step(I_BEQ, 1'b1, 4'h0, NONE, "beq_decode");
    step(I_BEQ, 1'b1, 4'h0, NONE, "beq_branch");
    check_eq("beq_branch_sel", 32'(sel_obs), 32'(9'b001001010));

    // ADDS R1,R2,R3 (1 + 0xFFFFFFFF): Z and C
    step(I_ADDS, 1'b1, 4'h0,    FOK,  "adds_fetch");
    step(I_ADDS, 1'b1, 4'h0,    NONE, "adds_decode");
    step(I_ADDS, 1'b1, 4'h0,    NONE, "adds_execr");
    step(I_ADDS, 1'b1, 4'b0110, RW,   "adds_aluwb");

    // BLEQ with Z set: taken with link
    step(I_BLEQ, 1'b1, 4'h0, FOK,     "bleq_fetch");
    check_eq("adds_flags", 32'(flags), 32'(4'b0110));
    step(I_BLEQ, 1'b1, 4'h0, NONE,    "bleq_decode");
    step(I_BLEQ, 1'b1, 4'h0, PCW|LW,  "bleq_branch");

    // CMP: flags only, no register write
    step(I_CMP, 1'b1, 4'h0,    FOK,  "cmp_fetch");
    step(I_CMP, 1'b1, 4'h0,    NONE, "cmp_decode");
    step(I_CMP, 1'b1, 4'h0,    NONE, "cmp_execr");
    check_eq("cmp_execr_sel", 32'(sel_obs), 32'(9'b000010000));
    step(I_CMP, 1'b1, 4'b1001, NONE, "cmp_aluwb");

    // ORRS: N/Z from the ALU, C/V keep their old values
    step(I_ORRS, 1'b1, 4'h0,    FOK,  "orrs_fetch");
    check_eq("cmp_flags", 32'(flags), 32'(4'b1001));
    step(I_ORRS, 1'b1, 4'h0,    NONE, "orrs_decode");
    step(I_ORRS, 1'b1, 4'h0,    NONE, "orrs_execr");
    step(I_ORRS, 1'b1, 4'b0110, RW,   "orrs_aluwb");
    check_eq("orrs_aluwb_sel", 32'(sel_obs), 32'(9'b000110000));

    // ADD R15,...: PC write instead of register write, flags untouched (no S)
    step(I_ADPC, 1'b1, 4'h0,    FOK,  "adpc_fetch");
    check_eq("orrs_flags", 32'(flags), 32'(4'b0101));
    step(I_ADPC, 1'b1, 4'h0,    NONE, "adpc_decode");
    step(I_ADPC, 1'b1, 4'h0,    NONE, "adpc_execr");
    step(I_ADPC, 1'b1, 4'b1111, PCW,  "adpc_aluwb");

    // STRB at byte lane 2 with three wait states
    step(I_STRB, 1'b1, 4'h0, FOK,  "strb_fetch");
    check_eq("adpc_flags", 32'(flags), 32'(4'b0101));
    step(I_STRB, 1'b1, 4'h0, NONE, "strb_decode");
    step(I_STRB, 1'b1, 4'h0, NONE, "strb_memadr");
    check_eq("strb_memadr_sel", 32'(sel_obs), 32'(9'b001000001));
    for (int k = 0; k < 3; k++)
      step(I_STRB, 1'b0, 4'h0, MREQ|ADR|MW|13'h0004, $sformatf("strb_wait%0d", k));
    step(I_STRB, 1'b1, 4'h0, MREQ|ADR|MW|13'h0004, "strb_done");

    // LDR that never completes: bus_err on the 15th wait cycle
    step(I_LDR, 1'b1, 4'h0, FOK,  "ldrto_fetch");
    step(I_LDR, 1'b1, 4'h0, NONE, "ldrto_decode");
    step(I_LDR, 1'b1, 4'h0, NONE, "ldrto_memadr");
    for (int k = 0; k < 14; k++)
      step(I_LDR, 1'b0, 4'h0, MREQ|ADR|13'h000F, $sformatf("ldrto_wait%0d", k));
    step(I_LDR, 1'b0, 4'h0, MREQ|ADR|BERR|13'h000F, "ldrto_buserr");
    step(I_LDR, 1'b0, 4'h0, MREQ, "ldrto_refetch");

    // LDR with ready arriving exactly at the timeout cycle: ready wins
    step(I_LDR, 1'b1, 4'h0, FOK,  "ldrrw_fetch");
    step(I_LDR, 1'b1, 4'h0, NONE, "ldrrw_decode");
    step(I_LDR, 1'b1, 4'h0, NONE, "ldrrw_memadr");
    for (int k = 0; k < 14; k++)
      step(I_LDR, 1'b0, 4'h0, MREQ|ADR|13'h000F, $sformatf("ldrrw_wait%0d", k));
    step(I_LDR, 1'b1, 4'h0, MREQ|ADR|13'h000F, "ldrrw_ready");
    step(I_LDR, 1'b1, 4'h0, RW, "ldrrw_memwb");

    // Undefined encodings: op 11, unsupported cmd, cond 1111
    step(I_OP11, 1'b1, 4'h0, FOK, "op11_fetch");
    step(I_OP11, 1'b1, 4'h0, ILL, "op11_decode");
    step(I_EOR,  1'b1, 4'h0, FOK, "eor_fetch");
    step(I_EOR,  1'b1, 4'h0, ILL, "eor_decode");
    step(I_NV,   1'b1, 4'h0, FOK, "nv_fetch");
    step(I_NV,   1'b1, 4'h0, ILL, "nv_decode");

    // Reset asserted mid-MEMWRITE drops the store immediately
    step(I_STR, 1'b1, 4'h0, FOK,  "str_fetch");
    step(I_STR, 1'b1, 4'h0, NONE, "str_decode");
    step(I_STR, 1'b1, 4'h0, NONE, "str_memadr");
    step(I_STR, 1'b0, 4'h0, MREQ|ADR|MW|13'h000F, "str_memwrite");
    #2;
    reset = 1'b0;
    #1;
    check_eq("str_rst_ctl", 32'(ctl_obs), 32'(MREQ));
    check_eq("str_rst_flags", 32'(flags), 32'(4'b0000));
    @(negedge clk);
    reset = 1'b1;
    step(I_STR, 1'b0, 4'h0, MREQ, "post_rst_fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Multicycle controller FSM for the ARM datapath (ADD/SUB/AND/ORR/CMP, LDR/STR/LDRB/STRB, B/BL).
- Decodes the latched instruction and drives the datapath select and enable lines state by state.
- Holds the NZCV condition flags and performs the condition check.
- Handles memory wait states through a ready handshake with a timeout.

Parameters:
- TIMEOUT_CYCLES, 15, maximum wait cycles per memory access before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- Instr  in  32  instruction register contents.
- ALUFlags  in  4  NZCV from ALU, current cycle.
- addr_lo  in  2  ALUResult[1:0], byte lane of the data address.
- mem_ready  in  1  memory completes the requested access this cycle.
- mem_req  out  1  memory access request, held until ready or timeout.
- PCWrite  out  1  load PC from Result.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUResult.
- IRWrite  out  1  latch instruction register.
- MemWrite  out  1  store strobe.
- be  out  4  byte enables.
- RegWrite  out  1  register file write.
- LinkWrite  out  1  write R14 with current PC (BL).
- RegSrc  out  2  register address selects.
- ImmSrc  out  2  immediate format.
- ALUSrcA  out  1  SrcA select: 0 = reg, 1 = PC.
- ALUSrcB  out  2  SrcB select: 0 = shifted reg, 1 = ExtImm, 2 = constant 4.
- ALUControl  out  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- ResultSrc  out  2  Result select: 0 = ALUOut reg, 1 = ReadData, 2 = ALUResult.
- flags  out  4  stored NZCV.
- illegal  out  1  one-cycle pulse on undefined instruction.
- bus_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: state = FETCH, flags = 0, wait counter = 0. All outputs 0 except those asserted by FETCH (mem_req = 1, AdrSrc = 0). Assertion mid-operation abandons the instruction immediately; no write completes.
- Outputs are Moore, decoded from state and Instr. Exceptions: IRWrite, PCWrite and MemWrite completion are qualified by mem_ready.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 1, ALUSrcB = 2, ALUControl = ADD, ResultSrc = 2. On mem_ready: IRWrite = 1, PCWrite = 1, go to DECODE. Otherwise stay.
- DECODE: ALUSrcA = 1, ALUSrcB = 2 (PC+8 available). Next state from op = Instr[27:26]:
  - 00: Instr[25] ? EXECI : EXECR.
  - 01: MEMADR.
  - 10: BRANCH.
  - 11: illegal pulse, go to FETCH.
  - Data-processing cmd Instr[24:21] outside {0100, 0010, 0000, 1100, 1010}: illegal pulse, go to FETCH.
- CondEx from Instr[31:28] against stored flags (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 treated as illegal). CondEx = 0 forces RegWrite, LinkWrite, MemWrite, flag update and PCWrite to 0 in every non-FETCH state. The FSM path is unchanged and mem_req is suppressed.
- MEMADR: ALUSrcB = 1, ImmSrc = 01, ADD. Next state: Instr[20] ? MEMREAD : MEMWRITE.
- MEMREAD: mem_req = 1, AdrSrc = 1. Go to MEMWB on mem_ready.
- MEMWRITE: mem_req = 1, AdrSrc = 1, MemWrite = 1. Go to FETCH on mem_ready.
- be:
  - Word access (Instr[22] = 0): 4'b1111.
  - Byte access (Instr[22] = 1): 4'b0001 << addr_lo.
  - be = 0 outside MEMREAD/MEMWRITE.
- MEMWB: ResultSrc = 1, RegWrite = 1. If Rd = 15: PCWrite = 1, RegWrite = 0. Then FETCH.
- EXECR (ALUSrcB = 0) / EXECI (ALUSrcB = 1, ImmSrc = 00) then ALUWB.
- ALUWB: ResultSrc = 0, RegWrite = 1 except for CMP.
  - If S = Instr[20] or CMP, flags update on this edge. N and Z always; C and V only for ADD/SUB/CMP.
  - Rd = 15 behaves as in MEMWB: PCWrite = 1 instead of RegWrite.
- BRANCH: ALUSrcA = 0, ALUSrcB = 1, ImmSrc = 10, ADD, ResultSrc = 2, PCWrite = CondEx. LinkWrite = CondEx & Instr[24]. Then FETCH.
- Wait counter: counts cycles in FETCH/MEMREAD/MEMWRITE without mem_ready and clears on state change.
  - Counter reaching TIMEOUT_CYCLES: bus_err pulse, go to FETCH, no IR/PC/register write.
  - mem_ready in the same cycle as timeout: ready wins, no bus_err.
- Latency with zero wait states: DP = 4 cycles, LDR = 5, STR = 4, B = 3.

Decomposition:
- Shared package arm_ctrl_pkg:
  - state enum.
  - op/cmd/cond encodings.
  - ALUControl, ResultSrc, ALUSrcB and ImmSrc constants.
- Sub-module condcheck (cond, flags -> CondEx), combinational and reused by the pipelined version.

Test Plan:
- ADDS R1,R2,R3 with R2 = 1, R3 = 0xFFFFFFFF, mem_ready = 1 -> 4 cycles; RegWrite in ALUWB; flags = 0110 (Z, C).
- BEQ with Z = 0 -> BRANCH has PCWrite = 0. BLEQ with Z = 1 -> PCWrite = 1, LinkWrite = 1; back in FETCH next cycle.
- STRB with addr_lo = 2, mem_ready low 3 cycles -> MemWrite and be = 0100 held for 4 cycles; FETCH on ready.
- LDR with mem_ready never asserted, TIMEOUT_CYCLES = 15 -> bus_err pulse on the 15th wait cycle; RegWrite never asserted; state = FETCH.
- Instr op = 11 -> illegal pulse in DECODE, next state FETCH, no writes. reset = 0 during MEMWRITE -> MemWrite drops asynchronously, state = FETCH, flags = 0.
